// File: rtl/bitwise_op_scheduler.sv
// Two-requester round-robin sequencer in front of a registered bitwise-logic unit.
// Optional per-requester completion counters are enabled with BITWISE_SCHED_STATS_EN.
module bitwise_op_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req_op0,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [2:0]       req_op1,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
`ifdef BITWISE_SCHED_STATS_EN
    output logic [15:0]      stat_cnt0,
    output logic [15:0]      stat_cnt1,
`endif
    output logic             busy
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Requesters hold valid and operands until accepted; the response is held until consumed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             grant_id;
    logic             accept;
    logic             complete;

    function automatic logic [WIDTH-1:0] bit_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a & b);
            3'd4:    r = ~(a | b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = ~req_valid[0];
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (state_q == ST_IDLE && req_valid != 2'b00) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    assign accept   = |(req_valid & req_ready);
    assign complete = (state_q == ST_RESP) && rsp_valid_q && rsp_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d         = grant_id ? req_op1 : req_op0;
                    a_d          = grant_id ? req_a1 : req_a0;
                    b_d          = grant_id ? req_b1 : req_b0;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = bit_op(op_q, a_q, b_q);
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (complete) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_q         <= 3'd0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef BITWISE_SCHED_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // Counters wrap naturally at 16 bits.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (complete) begin
            if (rsp_id_q) begin
                cnt1_d = cnt1_q + 16'd1;
            end else begin
                cnt0_d = cnt0_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign stat_cnt0 = cnt0_q;
    assign stat_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_bitwise_op_scheduler.sv
// Bench for bitwise_op_scheduler: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_bitwise_op_scheduler;
  localparam int W = 8;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [2:0]   req_op0, req_op1;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [W-1:0] rsp_data;
`ifdef BITWISE_SCHED_STATS_EN
  logic [15:0]  stat_cnt0, stat_cnt1;
`endif

  bitwise_op_scheduler #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_op1   (req_op1),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
`ifdef BITWISE_SCHED_STATS_EN
    .stat_cnt0 (stat_cnt0),
    .stat_cnt1 (stat_cnt1),
`endif
    .busy      (busy)
  );

  // driver state
  logic         d_rst;
  logic [1:0]   d_valid;
  logic [2:0]   d_op [2];
  logic [W-1:0] d_a [2];
  logic [W-1:0] d_b [2];
  logic         d_rsp_ready;

  // reference model and scoreboard
  logic [W:0]   exp_q[$];
  int           m_pend, m_age, m_last;
  int           m_cnt [2];
  int           acc_ids[$];
  int           acc_cyc[$];
  int           cyc;
  int           n_checks, n_errors;

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int i);
    d_valid[i] = 1'b1;
    d_op[i]    = 3'($urandom_range(0, 7));
    d_a[i]     = W'($urandom);
    d_b[i]     = W'($urandom);
  endtask

  // One clock cycle: drive, check, then advance the model past the coming edge.
  task automatic tick();
    logic [1:0] e_ready;
    int         g;
    logic       e_rsp;
    e_ready = 2'b00;
    g       = 0;
    @(negedge clk);
    rst       = d_rst;
    req_valid = d_valid;
    req_op0   = d_op[0];
    req_a0    = d_a[0];
    req_b0    = d_b[0];
    req_op1   = d_op[1];
    req_a1    = d_a[1];
    req_b1    = d_b[1];
    rsp_ready = d_rsp_ready;
    #1;
    if (m_pend == 0 && d_valid != 2'b00) begin
      if (d_valid == 2'b11) g = 1 - m_last;
      else g = d_valid[0] ? 0 : 1;
      e_ready = 2'b01 << g;
    end
    e_rsp = (m_pend != 0) && (m_age >= 1);
    chk("req_ready", req_ready, e_ready);
    chk("busy", busy, m_pend);
    chk("rsp_valid", rsp_valid, e_rsp);
    if (e_rsp) begin
      chk("rsp_id", rsp_id, exp_q[0][W]);
      chk("rsp_data", rsp_data, exp_q[0][W-1:0]);
    end
`ifdef BITWISE_SCHED_STATS_EN
    chk("stat_cnt0", stat_cnt0, m_cnt[0] % 65536);
    chk("stat_cnt1", stat_cnt1, m_cnt[1] % 65536);
`endif
    if (d_rst) begin
      m_pend = 0;
      m_last = 1;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      exp_q.delete();
    end else if (m_pend != 0) begin
      if (e_rsp && d_rsp_ready) begin
        m_cnt[exp_q[0][W] ? 1 : 0]++;
        void'(exp_q.pop_front());
        m_pend = 0;
      end else begin
        m_age++;
      end
    end else if (e_ready != 2'b00) begin
      exp_q.push_back({(g == 1), ref_op(d_op[g], d_a[g], d_b[g])});
      m_pend = 1;
      m_age  = 0;
      m_last = g;
      acc_ids.push_back(g);
      acc_cyc.push_back(cyc);
      d_valid[g] = 1'b0;
    end
    cyc++;
  endtask

  task automatic drain();
    d_valid     = 2'b00;
    d_rsp_ready = 1'b1;
    for (int k = 0; k < 10 && m_pend != 0; k++) tick();
    tick();
  endtask

  logic [W-1:0] op_tbl [8];
  logic [W-1:0] held_data;
  logic         held_id;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    op_tbl = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hA5};
    n_checks = 0; n_errors = 0; cyc = 0;
    d_rst = 1'b1; d_valid = 2'b00; d_rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin d_op[i] = 3'd0; d_a[i] = '0; d_b[i] = '0; end
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    req_op0 = 3'd0; req_a0 = '0; req_b0 = '0; req_op1 = 3'd0; req_a1 = '0; req_b1 = '0;
    repeat (3) @(posedge clk);
    m_pend = 0; m_age = 0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
    d_rst = 1'b0;

    // reset state
    tick();
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_busy", busy, 1'b0);

    // first transaction and its latency
    d_valid = 2'b01; d_op[0] = 3'd0; d_a[0] = 8'hF0; d_b[0] = 8'h3C;
    tick();
    tick();
    tick();
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp_data", rsp_data, 8'h30);
    chk("t1_rsp_id", rsp_id, 1'b0);
    drain();

    // opcode sweep
    for (int op = 0; op < 8; op++) begin
      d_valid = 2'b01; d_op[0] = 3'(op); d_a[0] = 8'hA5; d_b[0] = 8'h0F;
      d_rsp_ready = 1'b0;
      tick();
      tick();
      tick();
      chk("t2_op_result", rsp_data, op_tbl[op]);
      d_rsp_ready = 1'b1;
      tick();
    end
    drain();

    // both requesters continuously valid: alternating grants every 3 cycles
    acc_ids.delete(); acc_cyc.delete();
    d_rsp_ready = 1'b1;
    new_req(0); new_req(1);
    for (int k = 0; k < 13; k++) begin
      tick();
      if (!d_valid[0]) new_req(0);
      if (!d_valid[1]) new_req(1);
    end
    chk("t3_accept_count", acc_ids.size(), 5);
    for (int k = 1; k < acc_ids.size(); k++) begin
      chk("t3_alternate", acc_ids[k], 1 - acc_ids[k-1]);
      chk("t3_interval", acc_cyc[k] - acc_cyc[k-1], 3);
    end
    drain();

    // response back-pressure
    d_rsp_ready = 1'b0;
    new_req(0); new_req(1);
    tick();
    d_valid = 2'b11;
    tick();
    tick();
    held_data = rsp_data;
    held_id   = rsp_id;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold_valid", rsp_valid, 1'b1);
      chk("t4_hold_data", rsp_data, held_data);
      chk("t4_hold_id", rsp_id, held_id);
      chk("t4_req_ready", req_ready, 2'b00);
    end
    d_rsp_ready = 1'b1;
    d_valid = 2'b00;
    tick();
    tick();
    chk("t4_back_idle", busy, 1'b0);

    // reset during EXEC drops the operation
    new_req(0);
    d_valid = 2'b01;
    tick();
    d_valid = 2'b00;
    d_rst = 1'b1;
    tick();
    d_rst = 1'b0;
    tick();
    chk("t5_rsp_valid", rsp_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    repeat (3) tick();
    new_req(0); new_req(1);
    tick();
    chk("t5_first_tie", req_ready, 2'b01);
    drain();

    // random traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++)
        if (!d_valid[i] && $urandom_range(0, 2) == 0) new_req(i);
      d_rsp_ready = 1'($urandom_range(0, 1));
      d_rst = ($urandom_range(0, 99) == 0);
      tick();
      if (d_rst) d_valid = 2'b00;
      d_rst = 1'b0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
